// File: rtl/cop0_pkg.sv
// Shared definitions for the cop0_vic exception/interrupt controller:
// register map, STATUS field positions and exception vector indices.
package cop0_pkg;

  localparam logic [4:0] ADDR_STATUS  = 5'd1;
  localparam logic [4:0] ADDR_CAUSE   = 5'd2;
  localparam logic [4:0] ADDR_EPC     = 5'd3;
  localparam logic [4:0] ADDR_COUNT   = 5'd4;
  localparam logic [4:0] ADDR_COMPARE = 5'd5;

  localparam int ST_IE        = 0;
  localparam int ST_EXL       = 1;
  localparam int ST_VE        = 2;
  localparam int ST_EN_BASE   = 8;
  localparam int ST_EN_OVF    = ST_EN_BASE + 0;
  localparam int ST_EN_RI     = ST_EN_BASE + 1;
  localparam int ST_MASK_BASE = 10;

  localparam int VEC_OVF      = 0;
  localparam int VEC_RI       = 1;
  localparam int VEC_TIMER    = 2;
  localparam int VEC_IRQ_BASE = 3;

  localparam logic [31:0] STATUS_RESET = 32'h0000_0101;

endpackage

// File: rtl/cop0_timer.sv
// Free-running COUNT register with COMPARE match flag (TI).
// TI is sticky until software rewrites COMPARE.
module cop0_timer (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_count_load,
  input  logic        i_compare_load,
  input  logic [31:0] i_data,
  output logic [31:0] o_count,
  output logic [31:0] o_compare,
  output logic        o_ti
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        ti_q, ti_d;

  always_comb begin
    count_d   = i_count_load ? i_data : count_q + 32'd1;
    compare_d = i_compare_load ? i_data : compare_q;
    ti_d      = ti_q;
    if (count_d == compare_q) ti_d = 1'b1;
    // A COMPARE write acknowledges the interrupt, even against a match this cycle.
    if (i_compare_load) ti_d = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q   <= 32'd0;
      compare_q <= 32'hFFFF_FFFF;
      ti_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign o_count   = count_q;
  assign o_compare = compare_q;
  assign o_ti      = ti_q;

endmodule

// File: rtl/cop0_vic.sv
// Coprocessor-0 with maskable synchronised interrupts, COUNT/COMPARE timer,
// fixed-priority arbitration and optional vectored handler addresses.
module cop0_vic
  import cop0_pkg::*;
#(
  parameter int          NUM_IRQ      = 6,
  parameter logic [31:0] HANDLER_BASE = 32'h0000_0010,
  parameter int          VECTOR_SHIFT = 4,
  parameter int          SYNC_STAGES  = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_arithmetic_overflow,
  input  logic               i_unknown_command,
  input  logic               i_unknown_func,
  input  logic [NUM_IRQ-1:0] i_irq,
  input  logic               i_mtc0,
  input  logic               i_eret,
  input  logic [4:0]         i_address,
  input  logic [31:0]        i_data,
  input  logic [31:0]        i_pc_to_epc,
  output logic [31:0]        o_data,
  output logic [31:0]        o_epc_to_pc,
  output logic               o_exception,
  output logic [31:0]        o_handler_address,
  output logic               o_timer_irq
);

  localparam int NUM_REQ = NUM_IRQ + 3;
  localparam int TI_BIT  = ST_MASK_BASE + NUM_IRQ;

  logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [NUM_IRQ-1:0] irq_sync;
  logic [31:0]        status_q, status_d;
  logic [31:0]        epc_q, epc_d;
  logic [4:0]         cause_idx_q, cause_idx_d;
  logic [31:0]        cause_rd;
  logic [31:0]        count, compare;
  logic               ti;
  logic [NUM_REQ-1:0] req;
  logic               any_req;
  logic [4:0]         win_idx;
  logic               take;
  logic               wr_status, wr_count, wr_compare;

  assign wr_status  = i_mtc0 && (i_address == ADDR_STATUS);
  assign wr_count   = i_mtc0 && (i_address == ADDR_COUNT);
  assign wr_compare = i_mtc0 && (i_address == ADDR_COMPARE);

  cop0_timer u_timer (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_count_load   (wr_count),
    .i_compare_load (wr_compare),
    .i_data         (i_data),
    .o_count        (count),
    .o_compare      (compare),
    .o_ti           (ti)
  );

  // NOTE: synchroniser flops are reset too, so a reset mid-operation cannot
  // leave a stale interrupt level in the pipeline.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= i_irq;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign irq_sync = sync_q[SYNC_STAGES-1];

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would infer a latch.
  always_comb begin
    req            = '0;
    req[VEC_OVF]   = i_arithmetic_overflow & status_q[ST_EN_OVF];
    req[VEC_RI]    = (i_unknown_command | i_unknown_func) & status_q[ST_EN_RI];
    req[VEC_TIMER] = ti & status_q[TI_BIT];
    for (int k = 0; k < NUM_IRQ; k++)
      req[VEC_IRQ_BASE + k] = irq_sync[k] & status_q[ST_MASK_BASE + k];
  end

  // Lowest index wins: scan from the bottom priority upward so it overwrites last.
  always_comb begin
    win_idx = 5'd0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req[i]) win_idx = 5'(i);
  end

  assign any_req = |req;
  assign take    = status_q[ST_IE] & ~status_q[ST_EXL] & any_req;

  always_comb begin
    o_handler_address = HANDLER_BASE;
    if (status_q[ST_VE] && any_req)
      o_handler_address = HANDLER_BASE + (32'(win_idx) << VECTOR_SHIFT);
  end

  always_comb begin
    status_d = status_q;
    if (wr_status) begin
      status_d         = i_data;
      status_d[ST_EXL] = status_q[ST_EXL];
    end
    if (i_eret) status_d[ST_EXL] = 1'b0;
    if (take)   status_d[ST_EXL] = 1'b1;
    epc_d       = take ? i_pc_to_epc : epc_q;
    cause_idx_d = take ? win_idx : cause_idx_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      status_q    <= STATUS_RESET;
      epc_q       <= 32'd0;
      cause_idx_q <= 5'd0;
    end else begin
      status_q    <= status_d;
      epc_q       <= epc_d;
      cause_idx_q <= cause_idx_d;
    end
  end

  always_comb begin
    cause_rd                               = '0;
    cause_rd[4:0]                          = cause_idx_q;
    cause_rd[ST_MASK_BASE +: NUM_IRQ]      = irq_sync;
    cause_rd[TI_BIT]                       = ti;
  end

  always_comb begin
    case (i_address)
      ADDR_STATUS:  o_data = status_q;
      ADDR_CAUSE:   o_data = cause_rd;
      ADDR_EPC:     o_data = epc_q;
      ADDR_COUNT:   o_data = count;
      ADDR_COMPARE: o_data = compare;
      default:      o_data = 32'd0;
    endcase
  end

  assign o_epc_to_pc = epc_q;
  assign o_exception = take;
  assign o_timer_irq = ti;

endmodule

// File: tb/tb_cop0_vic.sv
// Self-checking bench for cop0_vic: reset register table, exceptions,
// vectored irqs, timer, priority, eret/take collision and async reset.
module tb_cop0_vic;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ovf, ucmd, ufunc, mtc0, eret;
  logic [5:0]  irq;
  logic [4:0]  addr;
  logic [31:0] wdata, pc, rdata, epc, handler;
  logic        exc, timer_irq;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    string       name;
    logic [4:0]  addr;
    logic [31:0] exp;
  } rd_vec_t;
  rd_vec_t vecs[8];

  cop0_vic dut (
    .i_clk                 (clk),
    .i_rst_n               (rst_n),
    .i_arithmetic_overflow (ovf),
    .i_unknown_command     (ucmd),
    .i_unknown_func        (ufunc),
    .i_irq                 (irq),
    .i_mtc0                (mtc0),
    .i_eret                (eret),
    .i_address             (addr),
    .i_data                (wdata),
    .i_pc_to_epc           (pc),
    .o_data                (rdata),
    .o_epc_to_pc           (epc),
    .o_exception           (exc),
    .o_handler_address     (handler),
    .o_timer_irq           (timer_irq)
  );

  always #10 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input string name, input logic [31:0] exp);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic observe(input logic [31:0] act);
    sb_t e;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard: output 0x%08h with no expectation", act);
    end else begin
      e = sb_q.pop_front();
      check(e.name, act, e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    mtc0  = 1'b1;
    addr  = a;
    wdata = d;
    tick();
    mtc0  = 1'b0;
    wdata = 32'd0;
  endtask

  task automatic exp_rd(input string name, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] d;
    push(name, exp);
    rd(a, d);
    observe(d);
  endtask

  task automatic exp_out(input string name, input logic [31:0] exp, input logic [31:0] act);
    push(name, exp);
    observe(act);
  endtask

  initial begin
    logic [31:0] c;
    rst_n = 1'b0; ovf = 0; ucmd = 0; ufunc = 0; mtc0 = 0; eret = 0;
    irq = '0; addr = '0; wdata = '0; pc = '0;

    vecs[0] = '{"rst_status",  5'd1,  32'h0000_0101};
    vecs[1] = '{"rst_cause",   5'd2,  32'h0000_0000};
    vecs[2] = '{"rst_epc",     5'd3,  32'h0000_0000};
    vecs[3] = '{"rst_count",   5'd4,  32'h0000_0000};
    vecs[4] = '{"rst_compare", 5'd5,  32'hFFFF_FFFF};
    vecs[5] = '{"rd_addr0",    5'd0,  32'h0000_0000};
    vecs[6] = '{"rd_addr6",    5'd6,  32'h0000_0000};
    vecs[7] = '{"rd_addr31",   5'd31, 32'h0000_0000};

    #1;
    exp_out("rst_exc", 32'(1'b0), 32'(exc));
    exp_out("rst_handler", 32'h10, handler);
    exp_out("rst_ti", 32'(1'b0), 32'(timer_irq));
    exp_out("rst_epc_out", 32'h0, epc);
    tick(); tick();
    rst_n = 1'b1;

    foreach (vecs[i]) push(vecs[i].name, vecs[i].exp);
    foreach (vecs[i]) begin
      rd(vecs[i].addr, c);
      observe(c);
    end
    tick();
    exp_rd("count_inc", 5'd4, 32'd1);

    // Synchronous overflow, then again while EXL is set.
    ovf = 1; pc = 32'h400; #1;
    exp_out("ovf_exc", 32'd1, 32'(exc));
    exp_out("ovf_handler", 32'h10, handler);
    tick(); ovf = 0;
    exp_rd("ovf_epc", 5'd3, 32'h400);
    exp_rd("ovf_cause", 5'd2, 32'h0);
    exp_rd("ovf_status", 5'd1, 32'h103);
    ovf = 1; pc = 32'h500; #1;
    exp_out("ovf_exl_exc", 32'd0, 32'(exc));
    tick(); ovf = 0;
    exp_rd("ovf_exl_epc", 5'd3, 32'h400);
    eret = 1; tick(); eret = 0;
    exp_rd("eret_status", 5'd1, 32'h101);

    // Vectored irq2 through the synchroniser.
    wr(5'd1, 32'h0000_1005);
    irq = 6'b000100; #1;
    exp_out("irq_lat0", 32'd0, 32'(exc));
    tick();
    exp_out("irq_lat1", 32'd0, 32'(exc));
    tick();
    exp_out("irq_lat2", 32'd1, 32'(exc));
    exp_out("irq_handler", 32'h60, handler);
    pc = 32'h800; tick();
    exp_rd("irq_cause", 5'd2, 32'h1005);
    exp_rd("irq_epc", 5'd3, 32'h800);
    exp_rd("irq_status", 5'd1, 32'h1007);
    eret = 1; #1;
    exp_out("irq_eret_exc", 32'd0, 32'(exc));
    tick(); eret = 0; #1;
    exp_out("irq_retake", 32'd1, 32'(exc));
    exp_rd("irq_eret_status", 5'd1, 32'h1005);
    pc = 32'h900; tick();
    irq = '0; tick(); tick();
    eret = 1; tick(); eret = 0; #1;
    exp_out("irq_clear_exc", 32'd0, 32'(exc));
    exp_rd("irq_epc2", 5'd3, 32'h900);

    // Timer: COMPARE = COUNT + 10.
    wr(5'd1, 32'h0001_0001);
    rd(5'd4, c);
    wr(5'd5, c + 32'd10);
    repeat (8) tick();
    exp_out("ti_early", 32'd0, 32'(timer_irq));
    exp_out("ti_early_exc", 32'd0, 32'(exc));
    tick();
    exp_out("ti_set", 32'd1, 32'(timer_irq));
    exp_out("ti_exc", 32'd1, 32'(exc));
    pc = 32'hA00; tick();
    exp_rd("ti_cause", 5'd2, 32'h1_0002);
    exp_rd("ti_epc", 5'd3, 32'hA00);
    wr(5'd5, 32'd0);
    exp_out("ti_cleared", 32'd0, 32'(timer_irq));
    eret = 1; tick(); eret = 0; #1;
    exp_out("ti_after_exc", 32'd0, 32'(exc));

    // Priority: overflow, timer and irq0 together.
    wr(5'd1, 32'h0001_0500);
    irq = 6'b000001;
    rd(5'd4, c);
    wr(5'd5, c + 32'd10);
    repeat (9) tick();
    exp_out("pri_ti", 32'd1, 32'(timer_irq));
    exp_out("pri_ie0_exc", 32'd0, 32'(exc));
    ovf = 1; pc = 32'hB00;
    wr(5'd1, 32'h0001_0505); #1;
    exp_out("pri_exc", 32'd1, 32'(exc));
    exp_out("pri_ovf_handler", 32'h10, handler);
    tick(); ovf = 0;
    exp_rd("pri_ovf_cause", 5'd2, 32'h1_0400);
    exp_rd("pri_ovf_epc", 5'd3, 32'hB00);
    eret = 1; tick(); eret = 0; #1;
    exp_out("pri_ti_exc", 32'd1, 32'(exc));
    exp_out("pri_ti_handler", 32'h30, handler);
    pc = 32'hC00; tick();
    exp_rd("pri_ti_cause", 5'd2, 32'h1_0402);
    exp_rd("pri_ti_epc", 5'd3, 32'hC00);

    // eret coinciding with a fresh take.
    wr(5'd5, 32'd0);
    irq = '0; tick(); tick();
    eret = 1; tick(); eret = 0; #1;
    exp_out("col_idle_exc", 32'd0, 32'(exc));
    exp_rd("col_idle_status", 5'd1, 32'h1_0505);
    irq = 6'b000001; tick();
    exp_out("col_lat1", 32'd0, 32'(exc));
    tick();
    exp_out("col_exc", 32'd1, 32'(exc));
    exp_out("col_handler", 32'h40, handler);
    eret = 1; pc = 32'hD00; tick(); eret = 0;
    exp_rd("col_status", 5'd1, 32'h1_0507);
    exp_rd("col_epc", 5'd3, 32'hD00);
    exp_rd("col_cause", 5'd2, 32'h403);

    // Asynchronous reset mid-handler.
    #2; rst_n = 1'b0; #1;
    exp_rd("arst_status", 5'd1, 32'h101);
    exp_out("arst_exc", 32'd0, 32'(exc));
    exp_out("arst_epc", 32'd0, epc);
    exp_out("arst_handler", 32'h10, handler);
    irq = '0; #1; rst_n = 1'b1;
    tick();

    // STATUS write coinciding with take; CAUSE/EXL write protection; COUNT wrap.
    ovf = 1; pc = 32'hE00; #1;
    exp_out("mtc_take_exc", 32'd1, 32'(exc));
    wr(5'd1, 32'h105); ovf = 0;
    exp_rd("mtc_take_status", 5'd1, 32'h107);
    exp_rd("mtc_take_epc", 5'd3, 32'hE00);
    wr(5'd2, 32'hFFFF_FFFF);
    exp_rd("cause_ro", 5'd2, 32'h0);
    wr(5'd1, 32'h101);
    exp_rd("exl_ro", 5'd1, 32'h103);
    wr(5'd4, 32'hFFFF_FFFE);
    exp_rd("count_load", 5'd4, 32'hFFFF_FFFE);
    exp_out("count_load_ti", 32'd0, 32'(timer_irq));
    tick();
    exp_rd("count_max", 5'd4, 32'hFFFF_FFFF);
    exp_out("count_max_ti", 32'd1, 32'(timer_irq));
    tick();
    exp_rd("count_wrap", 5'd4, 32'h0);
    exp_out("ti_sticky", 32'd1, 32'(timer_irq));

    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
